single_port_ram_16x8: RTL and testbench



---
 rtl/single_port_ram_pkg.sv | 13 +
 rtl/single_port_ram_16x8.sv | 69 ++++++
 tb/tb_single_port_ram_16x8.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/single_port_ram_pkg.sv
// Purpose : shared default sizes and word/address types for single_port_ram_16x8.
// Latency : n/a (types and constants only).
// Backpr. : n/a; no ports.
package single_port_ram_pkg;

  localparam int SPR_ADDR_W = 4;
  localparam int SPR_DATA_W = 8;
  localparam int SPR_DEPTH  = 16;

  typedef logic [SPR_ADDR_W-1:0] spr_addr_t;
  typedef logic [SPR_DATA_W-1:0] spr_data_t;

endpackage : single_port_ram_pkg

// File: rtl/single_port_ram_16x8.sv
// Purpose : single-port scratch RAM, DEPTH x DATA_W, shared read/write address, sync write.
// Latency : write visible one rising edge later; read 0 cycles, or 1 cycle with SINGLE_PORT_RAM_REG_OUT_EN.
// Backpr. : none; no handshake, every cycle is independent.
//
// Ports:
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset; clears every word and the read path
//   address      - word address shared by read and write
//   data_in      - write data
//   write_enable - high writes data_in to mem[address] at the next rising clk
//   data_out     - read data for mem[address]
//
// Build option: define SINGLE_PORT_RAM_REG_OUT_EN to register data_out (read-old-data
// on a same-address collision). Undefined gives the combinational read.
// DEPTH must equal 2**ADDR_W so every address decodes to a real word.
module single_port_ram_16x8
  import single_port_ram_pkg::*;
#(
  parameter int ADDR_W = SPR_ADDR_W,
  parameter int DATA_W = SPR_DATA_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_enable,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data;

  // Reset clears the whole array without a clock, so the store is a register
  // array rather than an inferred block RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_enable) begin
      mem_q[address] <= data_in;
    end
  end

  // Pre-edge contents: a same-address write only shows up after the edge.
  assign rd_data = mem_q[address];

`ifdef SINGLE_PORT_RAM_REG_OUT_EN
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;

  // Samples the array as it stood before this edge's write (read-old-data).
  assign data_out_d = rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
`else
  assign data_out = rd_data;
`endif

endmodule : single_port_ram_16x8

// File: tb/tb_single_port_ram_16x8.sv
// Purpose : directed self-checking bench for single_port_ram_16x8 (either read build).
// Latency : read checks wait one extra edge when SINGLE_PORT_RAM_REG_OUT_EN is defined.
// Backpr. : n/a.
module tb_single_port_ram_16x8;

  logic       clk;
  logic       rst_n;
  logic [3:0] address;
  logic [7:0] data_in;
  logic       write_enable;
  logic [7:0] data_out;

  int checks;
  int errors;

  single_port_ram_16x8 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .data_in      (data_in),
    .write_enable (write_enable),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a falling edge; inputs change only there.
  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    address      = a;
    data_in      = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    address      = a;
    write_enable = 1'b0;
`ifdef SINGLE_PORT_RAM_REG_OUT_EN
    @(posedge clk);
`endif
    #1;
    check(tag, data_out, exp);
    @(negedge clk);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    address      = 4'h2;
    data_in      = 8'h00;
    write_enable = 1'b0;

    // Reset state, and a write attempted during reset is ignored.
    #3;
    check("reset_out", data_out, 8'h00);
    @(negedge clk);
    address      = 4'h2;
    data_in      = 8'h77;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    check("write_in_reset", data_out, 8'h00);
    @(negedge clk);
    write_enable = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      read_chk($sformatf("post_reset_%0d", i), 4'(i), 8'h00);
    end

    // Full sweep: word = address ^ 0x5A; 0x0 -> 0x5A, 0xF -> 0x55.
    for (int i = 0; i < 16; i++) begin
      write_word(4'(i), 8'(i) ^ 8'h5A);
    end
    for (int i = 0; i < 16; i++) begin
      read_chk($sformatf("sweep_%0d", i), 4'(i), 8'(i) ^ 8'h5A);
    end

    // Basic write/read.
    write_word(4'h2, 8'hAA);
    read_chk("basic_aa", 4'h2, 8'hAA);

    // Write-enable gating.
    address      = 4'h2;
    data_in      = 8'hFF;
    write_enable = 1'b0;
    repeat (3) @(negedge clk);
    read_chk("we_gate", 4'h2, 8'hAA);

    // Same-address collision: 0x11 then 0x22 at address 3.
    write_word(4'h3, 8'h11);
    read_chk("coll_setup", 4'h3, 8'h11);
    address      = 4'h3;
    data_in      = 8'h22;
    write_enable = 1'b1;
`ifdef SINGLE_PORT_RAM_REG_OUT_EN
    @(posedge clk);
    #1;
    check("coll_reg_old", data_out, 8'h11);
    @(negedge clk);
    write_enable = 1'b0;
    @(posedge clk);
    #1;
    check("coll_reg_new", data_out, 8'h22);
    @(negedge clk);
`else
    #1;
    check("coll_before", data_out, 8'h11);
    @(posedge clk);
    #1;
    check("coll_after", data_out, 8'h22);
    @(negedge clk);
    write_enable = 1'b0;
`endif

    // Asynchronous reset between edges with words populated.
    read_chk("pre_rst_f", 4'hF, 8'h55);
    address = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", data_out, 8'h00);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      read_chk($sformatf("after_rst_%0d", i), 4'(i), 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_single_port_ram_16x8
